sata_dbg_trig_ctrl: RTL and testbench
=====================================

Name: sata_dbg_trig_ctrl

Overview:
Debug-side controller for the 128-bit ChipScope ILA trigger port in the SATA core. It multiplexes one of up to four 128-bit SATA debug probe groups onto the ILA TRIG0 bus and runs a two-stage masked-match trigger sequencer. The sequencer injects a hit flag into the captured word, so the ILA triggers on a single bit. It is configured through a small 32-bit register port from the host-side register block, and counts ILA TRIG_OUT events for status.

Parameters:
C_NUM_GRP, 4, number of probe groups (2..4)
C_DW, 128, probe group and ILA trigger width
C_CNT_W, 16, occurrence counter width

Ports:
CLK  in  1  single clock for all logic, shared with the ILA
RST  in  1  asynchronous, active-high reset
Grp_data  in  C_NUM_GRP*C_DW  concatenated probe groups; group g occupies [g*C_DW +: C_DW]
Grp_valid  in  C_NUM_GRP  per-group sample qualifier
Cfg_wr  in  1  register write strobe, one cycle
Cfg_rd  in  1  register read strobe, one cycle
Cfg_addr  in  4  word address
Cfg_wdata  in  32  write data
Cfg_rdata  out  32  read data, valid the cycle after Cfg_rd
Ila_trig  out  C_DW  to ILA TRIG0
Ila_trig_out  in  1  ILA TRIG_OUT
Trig_hit  out  1  one-cycle sequencer hit pulse
Armed  out  1  high when the state is S1 or S2

Behaviour:
- Reset: all registers 0, state IDLE, Ila_trig=0, Cfg_rdata=0, Trig_hit=0, Armed=0.
- Registers:
  - 0 CTRL: [0] arm, [2:1] grp, [3] rearm, [4] s2_en.
  - 1 STATUS (RO): [2:0] state, [15:8] hit_cnt, [23:16] ila_cnt. Any write to address 1 clears both counters.
  - 2/3/4: S1_MATCH, S1_MASK, S1_CFG ([1:0] lane, [31:16] count).
  - 5/6/7: S2_MATCH, S2_MASK, S2_CFG (same fields).
  - Unmapped addresses read 0; writes to them are ignored.
- grp >= C_NUM_GRP selects group 0.
- Datapath, registered every cycle, latency 1:
  - Ila_trig[C_DW-1] = hit
  - Ila_trig[C_DW-2] = Grp_valid[grp]
  - Ila_trig[C_DW-3:0] = selected data[C_DW-3:0]
- Stage compare: lane word = data[lane*32 +: 32]. Match when (lane & mask) == (match & mask). Mask = 0 always matches. Only cycles with Grp_valid[grp]=1 are evaluated.
- Occurrence count: a count field of 0 is treated as 1. The counter increments on each qualifying match. The stage completes on the match that makes the counter equal to count, and the counter is cleared on completion.
- State machine (IDLE, S1, S2, HIT, DONE):
  - IDLE -> S1: a CTRL write with arm=1.
  - S1 -> S2 on stage-1 completion, or S1 -> HIT directly if s2_en=0.
  - S2 -> HIT on stage-2 completion.
  - HIT lasts one cycle, then goes to S1 if rearm=1, else DONE.
  - DONE -> IDLE: a CTRL write with arm=0. A CTRL write with arm=1 goes to S1.
  - Any state -> IDLE on a CTRL write with arm=0.
- Hit alignment: Trig_hit and Ila_trig[C_DW-1] are asserted in the same cycle Ila_trig carries the sample that completed the final stage, i.e. the sample presented one cycle earlier.
- Mid-operation events:
  - CTRL write with arm=1 while in S1 or S2: restart in S1 with both counters cleared.
  - grp change while armed: same restart.
  - Stage config writes while armed: take effect on the next evaluated cycle; counters are not cleared.
  - A CTRL write and a qualifying match in the same cycle: the write wins and the match is discarded.
- Counters:
  - hit_cnt increments on each HIT and saturates at 255.
  - ila_cnt increments on each rising edge of Ila_trig_out and saturates at 255.
  - Clear and increment in the same cycle: the result is 0.
- Asynchronous RST mid-sequence returns everything to reset values on the next edge-free instant. The next arm starts from a clean state.

Decomposition:
- Package sata_dbg_pkg holds:
  - register address constants
  - CTRL and CFG field offsets
  - state encoding (IDLE=0, S1=1, S2=2, HIT=3, DONE=4)
  - lane width 32
- Sub-module sata_dbg_stage_cmp is instantiated twice. It contains:
  - lane select
  - masked compare
  - C_CNT_W occurrence counter with clear/enable inputs
  - a done output

Test Plan:
- Reset, then read addresses 0-7 -> all 0. Ila_trig=0. Read of address 9 -> 0.
- grp=2, Grp_data group 2 = 0xA5..A5 with valid=1 -> one cycle later Ila_trig[125:0] = group-2 bits, [126]=1, [127]=0.
- Setup: S1 match=0x27, mask=0xFF, lane=0, count=3, s2_en=0, arm. Drive the match on valid cycles 5, 9 and 12, plus an invalid-cycle match at 7 -> Trig_hit only at cycle 13, hit_cnt=1, state DONE.
- Two stages: S1 count 1 on 0x1, S2 lane=3 match 0xDEAD count 2, rearm=1. Drive two full sequences -> two Trig_hit pulses, hit_cnt=2, Armed stays 1.
- Mid-sequence abort: after one S1 match, change grp -> restart; the old partial count does not complete. Then a CTRL arm=0 write coinciding with the final match -> IDLE and no hit.
- Counter limits: 300 Ila_trig_out pulses -> ila_cnt=255. Write address 1 -> 0. Assert RST during S2 -> state IDLE, Armed=0.

Source files
------------

// File: rtl/sata_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sata_dbg_pkg
//  Purpose  : Shared constants and types for the SATA ILA trigger controller:
//             register map, CTRL/CFG field offsets, sequencer state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package sata_dbg_pkg;

    // Width of one compare lane inside a probe group
    localparam int C_LANE_W = 32;

    // Register word addresses
    localparam logic [3:0] C_ADDR_CTRL     = 4'd0;
    localparam logic [3:0] C_ADDR_STATUS   = 4'd1;
    localparam logic [3:0] C_ADDR_S1_MATCH = 4'd2;
    localparam logic [3:0] C_ADDR_S1_MASK  = 4'd3;
    localparam logic [3:0] C_ADDR_S1_CFG   = 4'd4;
    localparam logic [3:0] C_ADDR_S2_MATCH = 4'd5;
    localparam logic [3:0] C_ADDR_S2_MASK  = 4'd6;
    localparam logic [3:0] C_ADDR_S2_CFG   = 4'd7;

    // CTRL field offsets
    localparam int C_CTRL_ARM   = 0;
    localparam int C_CTRL_GRP   = 1;
    localparam int C_CTRL_REARM = 3;
    localparam int C_CTRL_S2_EN = 4;
    localparam int C_CTRL_W     = 5;

    // Stage CFG field offsets
    localparam int C_CFG_LANE_LSB  = 0;
    localparam int C_CFG_LANE_W    = 2;
    localparam int C_CFG_COUNT_LSB = 16;

    // Sequencer states; the encoding is visible in STATUS[2:0]
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_HIT  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sata_dbg_stage_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : sata_dbg_stage_cmp
//  Purpose  : One trigger stage: picks a 32-bit lane of the selected probe
//             word, does a masked compare and counts qualifying matches until
//             the configured occurrence count is reached.
//  Revision : 1.0 - initial release
// ============================================================================
module sata_dbg_stage_cmp
    import sata_dbg_pkg::*;
#(
    parameter int C_DW    = 128,
    parameter int C_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [C_DW-1:0]         data_i,
    input  logic [C_LANE_W-1:0]     match_i,
    input  logic [C_LANE_W-1:0]     mask_i,
    input  logic [C_CFG_LANE_W-1:0] lane_i,
    input  logic [C_CNT_W-1:0]      count_i,
    input  logic                    en_i,
    input  logic                    clr_i,
    output logic                    done_o
);

    localparam logic [C_CNT_W:0] C_ONE_X = (C_CNT_W+1)'(1);

    logic [C_LANE_W-1:0] w_lane_word;
    logic                w_match;
    logic [C_CNT_W-1:0]  w_target;
    logic [C_CNT_W:0]    w_cnt_inc;
    logic [C_CNT_W-1:0]  cnt_q;
    logic [C_CNT_W-1:0]  cnt_d;

    // Lane pick, masked compare, completion test and counter next-state.
    // Completion uses ">=" so that lowering the count while armed completes
    // on the next match instead of letting the counter run away.
    always_comb begin
        w_lane_word = data_i[int'(lane_i)*C_LANE_W +: C_LANE_W];
        w_match     = en_i && (((w_lane_word ^ match_i) & mask_i) == '0);
        w_target    = (count_i == '0) ? C_CNT_W'(1) : count_i;
        w_cnt_inc   = {1'b0, cnt_q} + C_ONE_X;
        done_o      = w_match && (w_cnt_inc >= {1'b0, w_target});
        cnt_d       = cnt_q;
        if (clr_i || done_o) begin
            cnt_d = '0;
        end else if (w_match) begin
            cnt_d = w_cnt_inc[C_CNT_W-1:0];
        end
    end

    // Occurrence counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sata_dbg_trig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sata_dbg_trig_ctrl
//  Purpose  : Probe-group mux onto the ILA TRIG0 bus plus a two-stage masked
//             match trigger sequencer, host register port and status counters.
//  Revision : 1.0 - initial release
// ============================================================================
module sata_dbg_trig_ctrl
    import sata_dbg_pkg::*;
#(
    parameter int C_NUM_GRP = 4,
    parameter int C_DW      = 128,
    parameter int C_CNT_W   = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [C_NUM_GRP*C_DW-1:0] Grp_data,
    input  logic [C_NUM_GRP-1:0]      Grp_valid,
    input  logic                      Cfg_wr,
    input  logic                      Cfg_rd,
    input  logic [3:0]                Cfg_addr,
    input  logic [31:0]               Cfg_wdata,
    output logic [31:0]               Cfg_rdata,
    output logic [C_DW-1:0]           Ila_trig,
    input  logic                      Ila_trig_out,
    output logic                      Trig_hit,
    output logic                      Armed
);

    logic [C_CTRL_W-1:0] ctrl_q;
    logic [31:0]         s1_match_q, s1_mask_q, s1_cfg_q;
    logic [31:0]         s2_match_q, s2_mask_q, s2_cfg_q;
    state_e              state_q, state_d;
    logic                hit_q, hit_d;
    logic [C_DW-1:0]     ila_q, ila_d;
    logic [7:0]          hit_cnt_q, hit_cnt_d;
    logic [7:0]          ila_cnt_q, ila_cnt_d;
    logic                ila_prev_q;
    logic [31:0]         rdata_q, rdata_d;

    logic [1:0]          w_grp;
    logic [C_DW-1:0]     w_sel_data;
    logic                w_sel_valid;
    logic                w_ctrl_wr, w_stat_wr;
    logic                w_s1_en, w_s1_clr, w_s1_done;
    logic                w_s2_en, w_s2_clr, w_s2_done;
    logic [31:0]         w_rdata;

    // Group mux; an out-of-range grp falls back to group 0
    always_comb begin
        w_grp       = ctrl_q[C_CTRL_GRP +: 2];
        w_sel_data  = Grp_data[C_DW-1:0];
        w_sel_valid = Grp_valid[0];
        for (int g = 1; g < C_NUM_GRP; g++) begin
            if (int'(w_grp) == g) begin
                w_sel_data  = Grp_data[g*C_DW +: C_DW];
                w_sel_valid = Grp_valid[g];
            end
        end
    end

    // Stage qualification: a CTRL write restarts everything and discards a
    // coincident match; a stage counter is held clear outside its own state.
    always_comb begin
        w_ctrl_wr = Cfg_wr && (Cfg_addr == C_ADDR_CTRL);
        w_stat_wr = Cfg_wr && (Cfg_addr == C_ADDR_STATUS);
        w_s1_en   = (state_q == ST_S1) && w_sel_valid && !w_ctrl_wr;
        w_s2_en   = (state_q == ST_S2) && w_sel_valid && !w_ctrl_wr;
        w_s1_clr  = w_ctrl_wr || (state_q != ST_S1);
        w_s2_clr  = w_ctrl_wr || (state_q != ST_S2);
    end

    sata_dbg_stage_cmp #(.C_DW(C_DW), .C_CNT_W(C_CNT_W)) u_stage1 (
        .clk_i   (CLK),
        .rst_i   (RST),
        .data_i  (w_sel_data),
        .match_i (s1_match_q),
        .mask_i  (s1_mask_q),
        .lane_i  (s1_cfg_q[C_CFG_LANE_LSB +: C_CFG_LANE_W]),
        .count_i (s1_cfg_q[C_CFG_COUNT_LSB +: C_CNT_W]),
        .en_i    (w_s1_en),
        .clr_i   (w_s1_clr),
        .done_o  (w_s1_done)
    );

    sata_dbg_stage_cmp #(.C_DW(C_DW), .C_CNT_W(C_CNT_W)) u_stage2 (
        .clk_i   (CLK),
        .rst_i   (RST),
        .data_i  (w_sel_data),
        .match_i (s2_match_q),
        .mask_i  (s2_mask_q),
        .lane_i  (s2_cfg_q[C_CFG_LANE_LSB +: C_CFG_LANE_W]),
        .count_i (s2_cfg_q[C_CFG_COUNT_LSB +: C_CNT_W]),
        .en_i    (w_s2_en),
        .clr_i   (w_s2_clr),
        .done_o  (w_s2_done)
    );

    // Sequencer next state; hit_d flags completion of the final stage
    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        if (w_ctrl_wr) begin
            state_d = Cfg_wdata[C_CTRL_ARM] ? ST_S1 : ST_IDLE;
        end else begin
            case (state_q)
                ST_S1: begin
                    if (w_s1_done) begin
                        if (ctrl_q[C_CTRL_S2_EN]) begin
                            state_d = ST_S2;
                        end else begin
                            state_d = ST_HIT;
                            hit_d   = 1'b1;
                        end
                    end
                end
                ST_S2: begin
                    if (w_s2_done) begin
                        state_d = ST_HIT;
                        hit_d   = 1'b1;
                    end
                end
                ST_HIT:  state_d = ctrl_q[C_CTRL_REARM] ? ST_S1 : ST_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Trigger word, saturating status counters and read mux
    always_comb begin
        ila_d = {hit_d, w_sel_valid, w_sel_data[C_DW-3:0]};

        hit_cnt_d = hit_cnt_q;
        ila_cnt_d = ila_cnt_q;
        if (w_stat_wr) begin
            hit_cnt_d = '0;
            ila_cnt_d = '0;
        end else begin
            if (hit_d && (hit_cnt_q != 8'hFF)) begin
                hit_cnt_d = hit_cnt_q + 8'd1;
            end
            if (Ila_trig_out && !ila_prev_q && (ila_cnt_q != 8'hFF)) begin
                ila_cnt_d = ila_cnt_q + 8'd1;
            end
        end

        case (Cfg_addr)
            C_ADDR_CTRL:     w_rdata = 32'(ctrl_q);
            C_ADDR_STATUS:   w_rdata = {8'h00, ila_cnt_q, hit_cnt_q, 5'h00, state_q};
            C_ADDR_S1_MATCH: w_rdata = s1_match_q;
            C_ADDR_S1_MASK:  w_rdata = s1_mask_q;
            C_ADDR_S1_CFG:   w_rdata = s1_cfg_q;
            C_ADDR_S2_MATCH: w_rdata = s2_match_q;
            C_ADDR_S2_MASK:  w_rdata = s2_mask_q;
            C_ADDR_S2_CFG:   w_rdata = s2_cfg_q;
            default:         w_rdata = '0;
        endcase
        rdata_d = Cfg_rd ? w_rdata : rdata_q;
    end

    // Host register writes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_q     <= '0;
            s1_match_q <= '0;
            s1_mask_q  <= '0;
            s1_cfg_q   <= '0;
            s2_match_q <= '0;
            s2_mask_q  <= '0;
            s2_cfg_q   <= '0;
        end else if (Cfg_wr) begin
            case (Cfg_addr)
                C_ADDR_CTRL:     ctrl_q     <= Cfg_wdata[C_CTRL_W-1:0];
                C_ADDR_S1_MATCH: s1_match_q <= Cfg_wdata;
                C_ADDR_S1_MASK:  s1_mask_q  <= Cfg_wdata;
                C_ADDR_S1_CFG:   s1_cfg_q   <= Cfg_wdata;
                C_ADDR_S2_MATCH: s2_match_q <= Cfg_wdata;
                C_ADDR_S2_MASK:  s2_mask_q  <= Cfg_wdata;
                C_ADDR_S2_CFG:   s2_cfg_q   <= Cfg_wdata;
                default:         ;
            endcase
        end
    end

    // Sequencer state, datapath and status registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            hit_q      <= 1'b0;
            ila_q      <= '0;
            hit_cnt_q  <= '0;
            ila_cnt_q  <= '0;
            ila_prev_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hit_q      <= hit_d;
            ila_q      <= ila_d;
            hit_cnt_q  <= hit_cnt_d;
            ila_cnt_q  <= ila_cnt_d;
            ila_prev_q <= Ila_trig_out;
            rdata_q    <= rdata_d;
        end
    end

    assign Ila_trig  = ila_q;
    assign Trig_hit  = hit_q;
    assign Cfg_rdata = rdata_q;
    assign Armed     = (state_q == ST_S1) || (state_q == ST_S2);

endmodule
`default_nettype wire

// File: tb/tb_sata_dbg_trig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sata_dbg_trig_ctrl
//  Purpose  : Self-checking bench for sata_dbg_trig_ctrl: register table,
//             directed sequencer scenarios and randomized traffic against a
//             behavioural model of the trigger rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sata_dbg_trig_ctrl;

    localparam int NG = 3;     // three groups so grp=3 exercises the fallback
    localparam int DW = 128;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NG*DW-1:0]  Grp_data;
    logic [NG-1:0]     Grp_valid;
    logic              Cfg_wr, Cfg_rd;
    logic [3:0]        Cfg_addr;
    logic [31:0]       Cfg_wdata;
    logic [31:0]       Cfg_rdata;
    logic [DW-1:0]     Ila_trig;
    logic              Ila_trig_out;
    logic              Trig_hit, Armed;

    sata_dbg_trig_ctrl #(.C_NUM_GRP(NG), .C_DW(DW), .C_CNT_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Grp_data     (Grp_data),
        .Grp_valid    (Grp_valid),
        .Cfg_wr       (Cfg_wr),
        .Cfg_rd       (Cfg_rd),
        .Cfg_addr     (Cfg_addr),
        .Cfg_wdata    (Cfg_wdata),
        .Cfg_rdata    (Cfg_rdata),
        .Ila_trig     (Ila_trig),
        .Ila_trig_out (Ila_trig_out),
        .Trig_hit     (Trig_hit),
        .Armed        (Armed)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0 idle, 1 stage one, 2 stage two, 3 hit, 4 done
    logic [4:0]  m_ctrl;
    logic [31:0] m_reg [0:15];
    int          m_phase, m_c1, m_c2, m_hitcnt, m_ilacnt;
    bit          m_prev;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic bit stage_match(input logic [DW-1:0] d, input logic [31:0] mt,
                                       input logic [31:0] mk, input logic [31:0] cfg);
        logic [31:0] w;
        w = d[cfg[1:0]*32 +: 32];
        return (w & mk) == (mt & mk);
    endfunction

    function automatic int occ(input logic [31:0] cfg);
        return (cfg[31:16] == 16'd0) ? 1 : int'(cfg[31:16]);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return {27'd0, m_ctrl};
        if (a == 4'd1) return {8'h00, 8'(m_ilacnt), 8'(m_hitcnt), 5'h00, 3'(m_phase)};
        if (a >= 4'd2 && a <= 4'd7) return m_reg[a];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_ctrl = '0;
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_phase = 0; m_c1 = 0; m_c2 = 0; m_hitcnt = 0; m_ilacnt = 0; m_prev = 0;
    endtask

    // Advance one clock: predict from the rules, then compare after the edge
    task automatic tick();
        int           sel;
        logic [DW-1:0] d;
        bit           v, hit, rdchk;
        logic [31:0]  e_rdata;
        logic [DW-1:0] e_ila;
        sel   = (int'(m_ctrl[2:1]) < NG) ? int'(m_ctrl[2:1]) : 0;
        d     = Grp_data[sel*DW +: DW];
        v     = Grp_valid[sel];
        hit   = 0;
        rdchk = Cfg_rd;
        e_rdata = m_read(Cfg_addr);
        if (Cfg_wr && Cfg_addr == 4'd0) begin
            m_phase = Cfg_wdata[0] ? 1 : 0;
            m_c1 = 0; m_c2 = 0;
        end else begin
            case (m_phase)
                1: if (v && stage_match(d, m_reg[2], m_reg[3], m_reg[4])) begin
                       m_c1++;
                       if (m_c1 >= occ(m_reg[4])) begin
                           m_c1 = 0;
                           if (m_ctrl[4]) m_phase = 2;
                           else begin m_phase = 3; hit = 1; end
                       end
                   end
                2: if (v && stage_match(d, m_reg[5], m_reg[6], m_reg[7])) begin
                       m_c2++;
                       if (m_c2 >= occ(m_reg[7])) begin
                           m_c2 = 0; m_phase = 3; hit = 1;
                       end
                   end
                3: m_phase = m_ctrl[3] ? 1 : 4;
                default: ;
            endcase
        end
        if (Cfg_wr && Cfg_addr == 4'd1) begin
            m_hitcnt = 0; m_ilacnt = 0;
        end else begin
            if (hit && m_hitcnt < 255) m_hitcnt++;
            if (Ila_trig_out && !m_prev && m_ilacnt < 255) m_ilacnt++;
        end
        m_prev = Ila_trig_out;
        if (Cfg_wr) begin
            if (Cfg_addr == 4'd0) m_ctrl = Cfg_wdata[4:0];
            else if (Cfg_addr >= 4'd2 && Cfg_addr <= 4'd7) m_reg[Cfg_addr] = Cfg_wdata;
        end
        e_ila = {hit, v, d[DW-3:0]};
        @(posedge CLK);
        #1;
        check("ila_trig", Ila_trig, e_ila);
        check("trig_hit", 128'(Trig_hit), 128'(hit));
        check("armed", 128'(Armed), 128'(m_phase == 1 || m_phase == 2));
        if (rdchk) check("rdata", 128'(Cfg_rdata), 128'(e_rdata));
        Cfg_wr = 1'b0;
        Cfg_rd = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        Cfg_wr = 1'b1; Cfg_addr = a; Cfg_wdata = d;
        tick();
    endtask

    task automatic rd(input logic [3:0] a);
        Cfg_rd = 1'b1; Cfg_addr = a;
        tick();
    endtask

    task automatic set_lane(input int g, input int lane, input logic [31:0] val);
        Grp_data[g*DW + lane*32 +: 32] = val;
    endtask

    initial begin
        int nhit, hit_at;
        logic [31:0] mk_set [4];
        RST = 1'b1; Grp_data = '0; Grp_valid = '0; Cfg_wr = 0; Cfg_rd = 0;
        Cfg_addr = '0; Cfg_wdata = '0; Ila_trig_out = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ila", Ila_trig, '0);
        check("rst_hit", 128'(Trig_hit), 128'(0));
        check("rst_armed", 128'(Armed), 128'(0));
        check("rst_rdata", 128'(Cfg_rdata), 128'(0));
        RST = 1'b0;

        // ---- register table ----
        for (int a = 0; a < 8; a++) vt.push_back('{1'b0, 1'b1, 4'(a), 32'h0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 4'd9,  32'h0, 32'h0});
        vt.push_back('{1'b0, 1'b1, 4'd15, 32'h0, 32'h0});
        vt.push_back('{1'b1, 1'b0, 4'd2,  32'h12345678, 32'h0});
        vt.push_back('{1'b0, 1'b1, 4'd2,  32'h0, 32'h12345678});
        vt.push_back('{1'b1, 1'b0, 4'd9,  32'hFFFFFFFF, 32'h0});
        vt.push_back('{1'b0, 1'b1, 4'd9,  32'h0, 32'h0});
        vt.push_back('{1'b1, 1'b0, 4'd7,  32'hABCD0003, 32'h0});
        vt.push_back('{1'b0, 1'b1, 4'd7,  32'h0, 32'hABCD0003});
        vt.push_back('{1'b1, 1'b0, 4'd0,  32'hFFFFFFE6, 32'h0});
        vt.push_back('{1'b0, 1'b1, 4'd0,  32'h0, 32'h00000006});
        vt.push_back('{1'b0, 1'b1, 4'd1,  32'h0, 32'h0});
        vt.push_back('{1'b1, 1'b0, 4'd2,  32'h0, 32'h0});
        vt.push_back('{1'b1, 1'b0, 4'd7,  32'h0, 32'h0});
        foreach (vt[i]) begin
            Cfg_wr = vt[i].wr; Cfg_rd = vt[i].rd; Cfg_addr = vt[i].addr; Cfg_wdata = vt[i].wdata;
            tick();
            if (vt[i].rd) check("tbl_rd", 128'(Cfg_rdata), 128'(vt[i].exp));
        end

        // ---- grp=3 with three groups falls back to group 0 ----
        Grp_data = '0;
        for (int l = 0; l < 4; l++) begin set_lane(0, l, 32'h0F0F_1234); set_lane(2, l, 32'hFFFF_FFFF); end
        Grp_valid = 3'b001;
        tick();
        check("grp_oob_data", 128'(Ila_trig[125:0]), {4{32'h0F0F_1234}} & {2'b00, {126{1'b1}}});
        check("grp_oob_valid", 128'(Ila_trig[126]), 128'(1));

        // ---- datapath with grp=2 ----
        wr(4'd0, 32'h4);
        Grp_data = '0;
        for (int l = 0; l < 4; l++) set_lane(2, l, 32'hA5A5_A5A5);
        Grp_valid = 3'b100;
        tick();
        check("dp_data", 128'(Ila_trig[125:0]), {4{32'hA5A5A5A5}} & {2'b00, {126{1'b1}}});
        check("dp_valid", 128'(Ila_trig[126]), 128'(1));
        check("dp_hitbit", 128'(Ila_trig[127]), 128'(0));

        // ---- single stage, count 3, invalid match ignored ----
        wr(4'd1, 0);
        wr(4'd2, 32'h27); wr(4'd3, 32'hFF); wr(4'd4, 32'h0003_0000);
        Grp_data = '0; Grp_valid = 3'b111;
        wr(4'd0, 32'h1);
        nhit = 0; hit_at = 0;
        for (int k = 1; k <= 14; k++) begin
            set_lane(0, 0, (k == 5 || k == 7 || k == 9 || k == 12) ? 32'h27 : 32'h11);
            Grp_valid = (k == 7) ? 3'b000 : 3'b111;
            tick();
            if (Trig_hit) begin nhit++; hit_at = k + 1; end
        end
        check("s1_hits", 128'(nhit), 128'(1));
        check("s1_hit_cycle", 128'(hit_at), 128'(13));
        rd(4'd1);
        check("s1_status", 128'(Cfg_rdata), 128'(32'h0000_0104));

        // ---- two stages with rearm ----
        wr(4'd1, 0);
        wr(4'd2, 32'h1); wr(4'd3, 32'hFFFF_FFFF); wr(4'd4, 32'h0001_0000);
        wr(4'd5, 32'hDEAD); wr(4'd6, 32'hFFFF_FFFF); wr(4'd7, 32'h0002_0003);
        wr(4'd0, 32'h19);
        nhit = 0;
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 7; s++) begin
                Grp_data = '0; Grp_valid = 3'b000;
                if (s == 0) begin set_lane(0, 0, 32'h1); Grp_valid = 3'b111; end
                if (s == 2 || s == 4) begin set_lane(0, 3, 32'hDEAD); Grp_valid = 3'b111; end
                tick();
                if (Trig_hit) nhit++;
            end
        end
        check("s2_hits", 128'(nhit), 128'(2));
        check("s2_armed", 128'(Armed), 128'(1));
        rd(4'd1);
        check("s2_status", 128'(Cfg_rdata), 128'(32'h0000_0201));

        // ---- restart on grp change, then disarm coinciding with final match ----
        wr(4'd2, 32'h1); wr(4'd3, 32'hFFFF_FFFF); wr(4'd4, 32'h0002_0000);
        Grp_data = '0; Grp_valid = 3'b000;
        wr(4'd0, 32'h01);
        nhit = 0;
        Grp_valid = 3'b111; set_lane(0, 0, 32'h1); set_lane(1, 0, 32'h1);
        tick(); if (Trig_hit) nhit++;
        set_lane(0, 0, 32'h0); set_lane(1, 0, 32'h0);
        wr(4'd0, 32'h03); if (Trig_hit) nhit++;
        set_lane(0, 0, 32'h1); set_lane(1, 0, 32'h1);
        tick(); if (Trig_hit) nhit++;
        wr(4'd0, 32'h02); if (Trig_hit) nhit++;
        tick(); if (Trig_hit) nhit++;
        check("abort_hits", 128'(nhit), 128'(0));
        check("abort_armed", 128'(Armed), 128'(0));
        rd(4'd1);
        check("abort_state", 128'(Cfg_rdata[2:0]), 128'(0));

        // ---- ila_cnt saturation and clear ----
        Grp_valid = '0;
        for (int i = 0; i < 300; i++) begin
            Ila_trig_out = 1'b1; tick();
            Ila_trig_out = 1'b0; tick();
        end
        rd(4'd1);
        check("ila_sat", 128'(Cfg_rdata[23:16]), 128'(255));
        wr(4'd1, 0);
        rd(4'd1);
        check("cnt_clear", 128'(Cfg_rdata[23:8]), 128'(0));

        // ---- asynchronous reset while in stage two ----
        wr(4'd2, 32'h1); wr(4'd3, 32'hFFFF_FFFF); wr(4'd4, 32'h0001_0000);
        wr(4'd0, 32'h11);
        Grp_data = '0; set_lane(0, 0, 32'h1); Grp_valid = 3'b111;
        tick();
        Grp_valid = '0;
        tick();
        check("pre_rst_armed", 128'(Armed), 128'(1));
        #2 RST = 1'b1;
        #1;
        check("async_rst_armed", 128'(Armed), 128'(0));
        check("async_rst_ila", Ila_trig, '0);
        @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
        rd(4'd1);
        check("post_rst_status", 128'(Cfg_rdata), 128'(0));

        // ---- randomized traffic against the model ----
        mk_set[0] = 32'h0; mk_set[1] = 32'h3; mk_set[2] = 32'hF; mk_set[3] = 32'h3_0000;
        for (int n = 0; n < 3000; n++) begin
            int r;
            for (int g = 0; g < NG; g++)
                for (int l = 0; l < 4; l++) set_lane(g, l, 32'($urandom_range(0, 3)));
            Grp_valid    = NG'($urandom);
            Ila_trig_out = 1'($urandom);
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                Cfg_wr = 1; Cfg_addr = 4'd0;
                Cfg_wdata = {$urandom} & 32'h1E;
                if ($urandom_range(0, 3) != 0) Cfg_wdata[0] = 1'b1;
            end else if (r <= 4) begin
                Cfg_wr = 1; Cfg_addr = 4'($urandom_range(2, 7));
                case (Cfg_addr)
                    4'd3, 4'd6: Cfg_wdata = mk_set[$urandom_range(0, 3)];
                    4'd4, 4'd7: Cfg_wdata = {16'($urandom_range(0, 3)), 16'($urandom)};
                    default:    Cfg_wdata = 32'($urandom_range(0, 3));
                endcase
            end else if (r == 5) begin
                Cfg_wr = 1; Cfg_addr = 4'd1; Cfg_wdata = $urandom;
            end else if (r == 6) begin
                Cfg_wr = 1; Cfg_addr = 4'($urandom_range(8, 15)); Cfg_wdata = $urandom;
            end
            if (r >= 5 && r <= 12) begin
                Cfg_rd = 1;
                if (!Cfg_wr) Cfg_addr = 4'($urandom_range(0, 15));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
